// File: rtl/au_gray2bin_pipe.sv
// au_gray2bin_pipe: Gray-code to binary converter with one registered output stage.
// The suffix-XOR (MSB downward) is built by the network chosen with ARCH:
//   0 = ripple chain, 1 = Sklansky, 2 = Kogge-Stone, 3 = Brent-Kung, others = ripple.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears b and b_vld
//   g      - Gray-coded input word, sampled when g_vld is high
//   g_vld  - input qualifier
//   b      - registered binary result
//   b_vld  - high for one cycle when b holds a new result
module au_gray2bin_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ARCH  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g,
  input  logic             g_vld,
  output logic [WIDTH-1:0] b,
  output logic             b_vld
);

  // Tree depth; at least one level so WIDTH = 1 still elaborates cleanly.
  localparam int unsigned LVL  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SEL  = (ARCH >= 1 && ARCH <= 3) ? ARCH : 0;
  localparam int unsigned NLEV = (SEL == 3) ? 2 * LVL : LVL;

  // Partner index that bit j combines with at tree level m, or -1 to pass through.
  // Indices are in reversed order (0 = input MSB), so the suffix-XOR becomes a prefix-XOR.
  function automatic int partner(input int sel, input int m, input int j);
    int r;
    int l;
    r = -1;
    l = 0;
    if (sel == 2) begin
      l = m;
      if (j >= (1 << l)) r = j - (1 << l);
    end else if (sel == 1) begin
      l = m;
      if (((j >> l) & 1) == 1) r = ((j >> (l + 1)) << (l + 1)) + (1 << l) - 1;
    end else if (sel == 3) begin
      if (m < int'(LVL)) begin
        // Up-sweep: complete power-of-two aligned groups.
        l = m;
        if (((j + 1) % (1 << (l + 1))) == 0) r = j - (1 << l);
      end else begin
        // Down-sweep: fill in the intermediate positions.
        l = 2 * int'(LVL) - 1 - m;
        if ((((j + 1) % (1 << (l + 1))) == (1 << l)) && (j >= (1 << (l + 1))))
          r = j - (1 << l);
      end
    end
    return r;
  endfunction

  logic [WIDTH-1:0] rev_g;
  logic [WIDTH-1:0] pfx;
  logic [WIDTH-1:0] b_nxt;

  // Bit-reverse in and out so every network is a plain prefix-XOR from index 0.
  for (genvar j = 0; j < WIDTH; j++) begin : g_rev
    assign rev_g[j]             = g[WIDTH-1-j];
    assign b_nxt[WIDTH-1-j]     = pfx[j];
  end

  if (SEL == 0) begin : g_ripple
    // Serial chain: each bit extends the running XOR of the bit before it.
    for (genvar j = 0; j < WIDTH; j++) begin : g_rip
      logic p;
      if (j == 0) begin : g_head
        assign p = rev_g[0];
      end else begin : g_link
        assign p = g_rip[j-1].p ^ rev_g[j];
      end
      assign pfx[j] = p;
    end
  end else begin : g_tree
    // One generate block per tree level; each level reads only the previous one.
    for (genvar m = 0; m < NLEV; m++) begin : g_lvl
      logic [WIDTH-1:0] src;
      logic [WIDTH-1:0] s;
      if (m == 0) begin : g_first
        assign src = rev_g;
      end else begin : g_next
        assign src = g_lvl[m-1].s;
      end
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        localparam int P = partner(int'(SEL), m, j);
        if (P >= 0) begin : g_op
          assign s[j] = src[j] ^ src[P];
        end else begin : g_pass
          assign s[j] = src[j];
        end
      end
    end
    assign pfx = g_lvl[NLEV-1].s;
  end

  // Output register: load on g_vld, hold otherwise; valid is a one-cycle echo of g_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b     <= '0;
      b_vld <= 1'b0;
    end else begin
      b_vld <= g_vld;
      if (g_vld) b <= b_nxt;
    end
  end

endmodule

// File: tb/tb_au_gray2bin_pipe.sv
// tb_au_gray2bin_pipe: checks 8-bit converters for ARCH 0,1,2,3,7, 32-bit converters for
// ARCH 0..3 and a 1-bit converter, all fed in lockstep from shared stimulus.
module tb_au_gray2bin_pipe;

  localparam int unsigned N8  = 5;
  localparam int unsigned N32 = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  g8;
  logic [31:0] g32;
  logic [0:0]  g1;
  logic        g_vld;

  logic [7:0]  b8  [N8];
  logic        v8  [N8];
  logic [31:0] b32 [N32];
  logic        v32 [N32];
  logic [0:0]  b1;
  logic        v1;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N8; k++) begin : g_d8
    au_gray2bin_pipe #(.WIDTH(8), .ARCH((k == 4) ? 7 : k)) u_dut (
      .clk(clk), .rst_n(rst_n), .g(g8), .g_vld(g_vld), .b(b8[k]), .b_vld(v8[k]));
  end

  for (genvar k = 0; k < N32; k++) begin : g_d32
    au_gray2bin_pipe #(.WIDTH(32), .ARCH(k)) u_dut (
      .clk(clk), .rst_n(rst_n), .g(g32), .g_vld(g_vld), .b(b32[k]), .b_vld(v32[k]));
  end

  au_gray2bin_pipe #(.WIDTH(1), .ARCH(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .g(g1), .g_vld(g_vld), .b(b1), .b_vld(v1));

  typedef struct {
    logic        vld;
    logic [7:0]  b8;
    logic [31:0] b32;
    logic        b1;
  } exp_t;

  typedef struct {
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  hold8;
  logic [31:0] hold32;
  logic        hold1;

  // Reference: walk from the MSB down accumulating the XOR of all bits seen so far.
  function automatic logic [31:0] g2b(input logic [31:0] gv, input int w);
    logic [31:0] r;
    logic        acc;
    r   = '0;
    acc = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      acc  = acc ^ gv[i];
      r[i] = acc;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < int'(N8); k++) begin
      check($sformatf("%s b8[%0d]", tag, k), 32'(b8[k]), 32'h0);
      check($sformatf("%s v8[%0d]", tag, k), 32'(v8[k]), 32'h0);
    end
    for (int k = 0; k < int'(N32); k++) begin
      check($sformatf("%s b32[%0d]", tag, k), b32[k], 32'h0);
      check($sformatf("%s v32[%0d]", tag, k), 32'(v32[k]), 32'h0);
    end
    check($sformatf("%s b1", tag), 32'(b1), 32'h0);
    check($sformatf("%s v1", tag), 32'(v1), 32'h0);
  endtask

  // Drive one cycle of stimulus, push its expectation, then pop and compare after the edge.
  task automatic step(input logic [7:0] a8, input logic [31:0] a32, input logic a1,
                      input logic vld);
    exp_t        e;
    logic [31:0] t;
    g8    = a8;
    g32   = a32;
    g1    = a1;
    g_vld = vld;
    if (vld) begin
      t      = g2b({24'h0, a8}, 8);
      hold8  = t[7:0];
      hold32 = g2b(a32, 32);
      t      = g2b({31'h0, a1}, 1);
      hold1  = t[0];
    end
    e.vld = vld;
    e.b8  = hold8;
    e.b32 = hold32;
    e.b1  = hold1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      e = sbq.pop_front();
      for (int k = 0; k < int'(N8); k++) begin
        check($sformatf("b8[%0d] g=%h", k, a8), 32'(b8[k]), 32'(e.b8));
        check($sformatf("v8[%0d]", k), 32'(v8[k]), 32'(e.vld));
      end
      for (int k = 0; k < int'(N32); k++) begin
        check($sformatf("b32[%0d] g=%h", k, a32), b32[k], e.b32);
        check($sformatf("v32[%0d]", k), 32'(v32[k]), 32'(e.vld));
      end
      check("b1", 32'(b1), 32'(e.b1));
      check("v1", 32'(v1), 32'(e.vld));
    end
  endtask

  initial begin
    vec_t tv[6];
    tv[0] = '{g: 8'h00, b: 8'h00};
    tv[1] = '{g: 8'h01, b: 8'h01};
    tv[2] = '{g: 8'h80, b: 8'hFF};
    tv[3] = '{g: 8'hC0, b: 8'h80};
    tv[4] = '{g: 8'h40, b: 8'h7F};
    tv[5] = '{g: 8'hFF, b: 8'hAA};

    g8     = '0;
    g32    = '0;
    g1     = '0;
    g_vld  = 1'b0;
    hold8  = '0;
    hold32 = '0;
    hold1  = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_reset("reset_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First conversion after release.
    step(8'hFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    for (int k = 0; k < int'(N8); k++) check($sformatf("first b8[%0d]", k), 32'(b8[k]), 32'hAA);
    check("first b1", 32'(b1), 32'h1);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      step(tv[i].g, $urandom, tv[i].g[0], 1'b1);
      for (int k = 0; k < int'(N8); k++)
        check($sformatf("table g=%h b8[%0d]", tv[i].g, k), 32'(b8[k]), 32'(tv[i].b));
    end

    // Hold when g_vld is low.
    step(8'h80, $urandom, 1'b1, 1'b1);
    step(8'h01, $urandom, 1'b0, 1'b0);
    for (int k = 0; k < int'(N8); k++) begin
      check($sformatf("hold b8[%0d]", k), 32'(b8[k]), 32'hFF);
      check($sformatf("hold v8[%0d]", k), 32'(v8[k]), 32'h0);
    end

    // Exhaustive 8-bit stream, back-to-back.
    for (int i = 0; i < 256; i++) step(8'(i), $urandom, 1'(i), 1'b1);

    // Mid-stream reset with a conversion pending.
    step(8'h5A, $urandom, 1'b1, 1'b1);
    g8    = 8'h33;
    g32   = 32'h1234_5678;
    g_vld = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("reset_mid");
    @(posedge clk);
    #1 check_reset("reset_held");
    g_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    hold8  = '0;
    hold32 = '0;
    hold1  = 1'b0;
    step(8'h77, $urandom, 1'b1, 1'b0);
    step(8'hC0, 32'h8000_0000, 1'b1, 1'b1);

    // Random 32-bit words (8-bit lanes randomised alongside).
    for (int i = 0; i < 10000; i++) step(8'($urandom), $urandom, 1'($urandom), 1'b1);

    // 32-bit corners.
    step(8'h00, 32'h0000_0000, 1'b0, 1'b1);
    for (int k = 0; k < int'(N32); k++) check($sformatf("zero b32[%0d]", k), b32[k], 32'h0);
    step(8'hFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    for (int k = 0; k < int'(N32); k++) check($sformatf("ones b32[%0d]", k), b32[k], 32'hAAAA_AAAA);
    step(8'h00, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/au_gray2bin_pipe.md
Name: au_gray2bin_pipe

Overview:
- Parameterized Gray-code to binary converter with a registered output stage.
- Used in the arithmetic-unit library wherever Gray-coded values are decoded, e.g. counters or pointers crossing clock domains.
- The combinational prefix-XOR network is selectable by ARCH, trading speed against area.
- One clock; output registered with a valid flag.

Parameters:
- WIDTH, 8, word length of g and b; legal range is 1 or more.
- ARCH, 0, prefix architecture:
  - 0 = serial ripple XOR chain
  - 1 = Sklansky
  - 2 = Kogge-Stone
  - 3 = Brent-Kung
  - any other value behaves as 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- g  input  WIDTH  Gray-coded input word.
- g_vld  input  1  input qualifier; g is sampled when high.
- b  output  WIDTH  binary result, registered.
- b_vld  output  1  high for one cycle when b holds a new result.

Behaviour:
- Function, bit-exact for all ARCH values:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0
  - Equivalently, b[i] is the XOR of g[WIDTH-1:i], a suffix-XOR computed from the MSB downward.
- WIDTH = 1: b = g.
- ARCH selects only the structure of the combinational network; results are identical for every ARCH.
  - ARCH 0: ripple chain, depth WIDTH-1.
  - ARCH 1, 2, 3: log2-depth prefix trees over the XOR operator, running from the MSB down.
- Latency: exactly 1 cycle.
  - On the rising edge where g_vld = 1, b is loaded with f(g) and b_vld is set to 1.
  - On an edge where g_vld = 0, b holds its previous value and b_vld goes to 0.
- Throughput: one conversion per cycle. Back-to-back g_vld is supported, with no bubbles and no backpressure.
- Reset:
  - rst_n low asynchronously forces b = 0 and b_vld = 0 immediately, regardless of clk.
  - Reset asserted mid-stream discards any pending conversion.
  - After release, the first edge with g_vld = 1 produces a result one cycle later.
- No X propagation from unused ARCH branches: only the selected network is generated.
- No internal state other than the b and b_vld registers.
- Overflow and wrap-around are not applicable: the mapping is a bijection on WIDTH bits.
  - Binary all-ones corresponds to Gray 1000...0; Gray 0 maps to 0.

Test Plan:
- Reset check: assert rst_n = 0 without a clock edge -> b = 8'h00 and b_vld = 0 immediately. Release, then drive g = 8'hFF with g_vld = 1 -> on the next edge b = 8'hAA and b_vld = 1.
- Directed values, WIDTH = 8, each one cycle after g_vld:
  - g = 8'h00 -> b = 8'h00
  - g = 8'h01 -> 8'h01
  - g = 8'h80 -> 8'hFF
  - g = 8'hC0 -> 8'h80
  - g = 8'h40 -> 8'h7F
- Exhaustive check for each ARCH 0..3 and WIDTH 8:
  - Drive all 256 g values back-to-back with g_vld = 1.
  - Compare b against the serial suffix-XOR model one cycle later; require 0 mismatches.
  - b_vld must stay 1 throughout the stream.
- Hold and valid:
  - Drive g = 8'h80 with g_vld = 1, then g = 8'h01 with g_vld = 0 -> b stays 8'hFF and b_vld drops to 0.
  - Mid-stream rst_n pulse -> b = 0 and b_vld = 0 asynchronously.
- Width corners:
  - WIDTH = 1: g = 1 -> b = 1.
  - WIDTH = 32: 10000 random g values plus all-zeros (-> 0) and all-ones (-> 32'hAAAAAAAA), checked against the model for every ARCH.
- Illegal ARCH: ARCH = 7 with WIDTH = 8, exhaustive -> results identical to ARCH 0.
